// File: rtl/insn_decode_stage_pkg.sv
// Shared ISA types for the decode stage.
// Kinds, decoded bundle, stage state and field limits.
package insn_decode_stage_pkg;

   typedef enum logic [2:0] {
      KIND_SET     = 3'd0,
      KIND_BRANCH  = 3'd1,
      KIND_JUMP    = 3'd2,
      KIND_OP      = 3'd3,
      KIND_NOP     = 3'd4,
      KIND_HLT     = 3'd5,
      KIND_ILLEGAL = 3'd6
   } insn_kind_e;

   typedef struct packed {
      insn_kind_e  kind;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [4:0]  func;
      logic [15:0] imm;
      logic        relative;
      logic [15:0] pc;
   } decoded_insn_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } decode_state_e;

   localparam logic [4:0]  FUNC_MAX = 5'h10;
   localparam logic [15:0] INSN_HLT = 16'h0000;
   localparam logic [15:0] INSN_NOP = 16'h0001;

endpackage

// File: rtl/insn_field_decode.sv
// Combinational field decoder: word + pc -> decoded bundle.
// Unused fields stay zero so execute never sees stale bits.
module insn_field_decode
   import insn_decode_stage_pkg::*;
(
   input  logic [15:0]   insn_i,
   input  logic [15:0]   pc_i,
   output decoded_insn_t dec_o
);

   logic is_hlt;
   logic is_nop;
   logic is_set;
   logic is_bj;
   logic is_op;

   assign is_hlt = (insn_i == INSN_HLT);
   assign is_nop = (insn_i == INSN_NOP);
   assign is_set = insn_i[15];
   assign is_bj  = (insn_i[15:14] == 2'b01);
   assign is_op  = (insn_i[15:13] == 3'b001)
                 && (insn_i[4:0] <= FUNC_MAX);

   // Classes are disjoint, so one-hot selection is safe.
   always_comb begin
      dec_o      = '0;
      dec_o.pc   = pc_i;
      dec_o.kind = KIND_ILLEGAL;
      unique case (1'b1)
         is_hlt: dec_o.kind = KIND_HLT;
         is_nop: dec_o.kind = KIND_NOP;
         is_set: begin
            dec_o.kind = KIND_SET;
            dec_o.ra   = insn_i[14:11];
            dec_o.imm  = {5'b0, insn_i[10:0]};
         end
         is_bj: begin
            dec_o.kind     = insn_i[13] ? KIND_BRANCH
                                        : KIND_JUMP;
            dec_o.relative = insn_i[12];
            dec_o.imm      = {{4{insn_i[12] & insn_i[11]}},
                              insn_i[11:0]};
         end
         is_op: begin
            dec_o.kind = KIND_OP;
            dec_o.ra   = insn_i[12:9];
            dec_o.rb   = insn_i[8:5];
            dec_o.func = insn_i[4:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/insn_decode_stage.sv
// Decode stage: output register + one-entry skid, halt/fault FSM,
// and a wrapping count of emitted instructions.
module insn_decode_stage
   import insn_decode_stage_pkg::*;
#(
   parameter bit DROP_NOP    = 1'b1,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [15:0]            in_insn,
   input  logic [15:0]            in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output insn_kind_e             out_kind,
   output logic [3:0]             out_ra,
   output logic [3:0]             out_rb,
   output logic [4:0]             out_func,
   output logic [15:0]            out_imm,
   output logic                   out_relative,
   output logic [15:0]            out_pc,
   output logic                   halted,
   output logic                   fault,
   input  logic                   resume,
   input  logic                   flush,
   output logic [COUNT_WIDTH-1:0] emit_count
);

   decoded_insn_t          dec;
   decoded_insn_t          out_q, out_d;
   decoded_insn_t          skid_q, skid_d;
   logic                   out_valid_q, out_valid_d;
   logic                   skid_valid_q, skid_valid_d;
   logic                   rdy_en_q;
   decode_state_e          state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   accept;
   logic                   emit;
   logic                   drop;
   logic                   load;
   logic                   out_free;

   insn_field_decode u_dec (
      .insn_i (in_insn),
      .pc_i   (in_pc),
      .dec_o  (dec)
   );

   // Ready depends only on registers; rdy_en_q holds it low in reset.
   assign in_ready = rdy_en_q && (state_q == ST_RUN)
                   && !skid_valid_q;
   assign accept   = in_valid && in_ready;
   assign emit     = out_valid_q && out_ready;
   assign drop     = DROP_NOP && (dec.kind == KIND_NOP);
   assign load     = accept && !drop && !flush;
   assign out_free = !out_valid_q || out_ready;

   // Output register fills from skid first, else from the new word.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_free) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = load;
            if (load) out_d = dec;
         end
      end else if (load) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   // Emit counter wraps naturally; flush leaves it alone.
   always_comb begin
      cnt_d = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, emit};
   end

   // FSM next state: flush wins, then accepted HLT/ILLEGAL, then resume.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (accept && dec.kind == KIND_HLT)
                  state_d = ST_HALTED;
               else if (accept && dec.kind == KIND_ILLEGAL)
                  state_d = ST_FAULT;
            end
            ST_HALTED: if (resume) state_d = ST_RUN;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_RUN;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      halted = (state_q == ST_HALTED);
      fault  = (state_q == ST_FAULT);
   end

   // State, buffers and counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         rdy_en_q     <= 1'b0;
         state_q      <= ST_RUN;
         cnt_q        <= '0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         rdy_en_q     <= 1'b1;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_kind     = out_q.kind;
   assign out_ra       = out_q.ra;
   assign out_rb       = out_q.rb;
   assign out_func     = out_q.func;
   assign out_imm      = out_q.imm;
   assign out_relative = out_q.relative;
   assign out_pc       = out_q.pc;
   assign emit_count   = cnt_q;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Bench for insn_decode_stage: directed steps, then random traffic
// against a queue-based reference model of the stage.
module tb_insn_decode_stage;
   import insn_decode_stage_pkg::*;

   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_insn;
   logic [15:0]   in_pc;
   logic          out_valid;
   logic          out_ready;
   insn_kind_e    out_kind;
   logic [3:0]    out_ra;
   logic [3:0]    out_rb;
   logic [4:0]    out_func;
   logic [15:0]   out_imm;
   logic          out_relative;
   logic [15:0]   out_pc;
   logic          halted;
   logic          fault;
   logic          resume;
   logic          flush;
   logic [CW-1:0] emit_count;

   int checks;
   int failures;

   decoded_insn_t q[$];
   int            st;
   int            cnt;
   bit            started;

   insn_decode_stage #(
      .DROP_NOP    (1'b1),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_insn      (in_insn),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_kind     (out_kind),
      .out_ra       (out_ra),
      .out_rb       (out_rb),
      .out_func     (out_func),
      .out_imm      (out_imm),
      .out_relative (out_relative),
      .out_pc       (out_pc),
      .halted       (halted),
      .fault        (fault),
      .resume       (resume),
      .flush        (flush),
      .emit_count   (emit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic decoded_insn_t ref_decode(
      logic [15:0] w, logic [15:0] pc);
      decoded_insn_t d;
      int u;
      int v;
      d    = '0;
      d.pc = pc;
      u    = int'(w);
      if (u == 0) d.kind = KIND_HLT;
      else if (u == 1) d.kind = KIND_NOP;
      else if (u >= 32768) begin
         d.kind = KIND_SET;
         d.ra   = 4'((u / 2048) % 16);
         d.imm  = 16'(u % 2048);
      end else if (u >= 16384) begin
         d.kind     = ((u / 8192) % 2 == 1) ? KIND_BRANCH
                                             : KIND_JUMP;
         d.relative = ((u / 4096) % 2 == 1);
         v = u % 4096;
         if (d.relative && v >= 2048) v = v + 61440;
         d.imm = 16'(v);
      end else if (u >= 8192 && (u % 32) <= 16) begin
         d.kind = KIND_OP;
         d.ra   = 4'((u / 512) % 16);
         d.rb   = 4'((u / 32) % 16);
         d.func = 5'(u % 32);
      end else d.kind = KIND_ILLEGAL;
      return d;
   endfunction

   function automatic bit exp_ready();
      return started && st == 0 && q.size() <= 1;
   endfunction

   task automatic compare();
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("halted", 32'(halted), 32'(st == 1));
      chk("fault", 32'(fault), 32'(st == 2));
      chk("emit_count", 32'(emit_count), 32'(cnt));
      if (q.size() > 0) begin
         chk("kind", 32'(out_kind), 32'(q[0].kind));
         chk("ra", 32'(out_ra), 32'(q[0].ra));
         chk("rb", 32'(out_rb), 32'(q[0].rb));
         chk("func", 32'(out_func), 32'(q[0].func));
         chk("imm", 32'(out_imm), 32'(q[0].imm));
         chk("rel", 32'(out_relative), 32'(q[0].relative));
         chk("pc", 32'(out_pc), 32'(q[0].pc));
      end
   endtask

   task automatic cycle(output bit acc);
      bit emt;
      decoded_insn_t d;
      acc = in_valid && exp_ready();
      emt = (q.size() > 0) && out_ready;
      @(posedge clk);
      if (emt) begin
         void'(q.pop_front());
         cnt = (cnt + 1) % (1 << CW);
      end
      if (flush) begin
         q.delete();
         st = 0;
      end else if (acc) begin
         d = ref_decode(in_insn, in_pc);
         if (d.kind != KIND_NOP) q.push_back(d);
         if (d.kind == KIND_HLT) st = 1;
         else if (d.kind == KIND_ILLEGAL) st = 2;
      end else if (st == 1 && resume) st = 0;
      started = 1'b1;
      @(negedge clk);
      compare();
   endtask

   task automatic drv(bit v, logic [15:0] w, logic [15:0] pc,
                      bit ordy, bit res, bit fl);
      bit acc;
      in_valid  = v;
      in_insn   = w;
      in_pc     = pc;
      out_ready = ordy;
      resume    = res;
      flush     = fl;
      cycle(acc);
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 9))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2, 3:    return 16'h8000 | r;
         4, 5:    return 16'h4000 | (r & 16'h3FFF);
         6, 7:    return 16'h2000 | (r & 16'h1FFF);
         8:       return 16'h2000 | (r & 16'h1FE0)
                       | 16'($urandom_range(0, 16));
         default: return r;
      endcase
   endfunction

   initial begin
      logic [15:0] words [6];
      int idx;
      int c0;
      bit acc;

      checks   = 0;
      failures = 0;
      q.delete();
      st = 0;
      cnt = 0;
      started = 1'b0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_insn = '0;
      in_pc = '0;
      out_ready = 1'b0;
      resume = 1'b0;
      flush = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      compare();
      chk("rst_kind", 32'(out_kind), 32'd0);
      chk("rst_imm", 32'(out_imm), 32'd0);
      chk("rst_pc", 32'(out_pc), 32'd0);
      rst_n = 1'b1;

      drv(0, 16'h0, 16'h0, 1, 0, 0);
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      drv(1, 16'hB405, 16'h0010, 1, 0, 0);
      chk("set_kind", 32'(out_kind), 32'(KIND_SET));
      chk("set_ra", 32'(out_ra), 32'd6);
      chk("set_imm", 32'(out_imm), 32'h0405);
      chk("set_pc", 32'(out_pc), 32'h0010);

      drv(1, 16'h26A1, 16'h0012, 1, 0, 0);
      chk("op_kind", 32'(out_kind), 32'(KIND_OP));
      chk("op_ra", 32'(out_ra), 32'd3);
      chk("op_rb", 32'(out_rb), 32'd5);
      chk("op_func", 32'(out_func), 32'd1);

      drv(1, 16'h7FFC, 16'h0014, 1, 0, 0);
      chk("br_kind", 32'(out_kind), 32'(KIND_BRANCH));
      chk("br_rel", 32'(out_relative), 32'd1);
      chk("br_imm", 32'(out_imm), 32'hFFFC);

      drv(1, 16'h4123, 16'h0016, 1, 0, 0);
      chk("jmp_kind", 32'(out_kind), 32'(KIND_JUMP));
      chk("jmp_rel", 32'(out_relative), 32'd0);
      chk("jmp_imm", 32'(out_imm), 32'h0123);

      drv(1, 16'h0000, 16'h0018, 1, 0, 0);
      chk("hlt_kind", 32'(out_kind), 32'(KIND_HLT));
      chk("hlt_halted", 32'(halted), 32'd1);
      drv(1, 16'hB405, 16'h001A, 1, 0, 0);
      chk("hlt_noready", 32'(in_ready), 32'd0);
      drv(0, 16'h0, 16'h0, 1, 1, 0);
      chk("resume_halted", 32'(halted), 32'd0);
      chk("resume_ready", 32'(in_ready), 32'd1);

      drv(1, 16'h2011, 16'h0020, 0, 0, 0);
      chk("ill_kind", 32'(out_kind), 32'(KIND_ILLEGAL));
      chk("ill_fault", 32'(fault), 32'd1);
      drv(0, 16'h0, 16'h0, 0, 1, 0);
      chk("ill_resume", 32'(fault), 32'd1);
      drv(0, 16'h0, 16'h0, 0, 0, 1);
      chk("flush_fault", 32'(fault), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ready", 32'(in_ready), 32'd1);

      words = '{16'h8801, 16'h4007, 16'h2A42,
                16'h6FFF, 16'hF7FF, 16'h5800};
      c0  = cnt;
      idx = 0;
      for (int c = 0; c < 16; c++) begin
         in_valid  = (idx < 6);
         in_insn   = words[idx < 6 ? idx : 0];
         in_pc     = 16'(16'h0100 + 2 * idx);
         out_ready = !(c >= 2 && c < 5);
         resume    = 1'b0;
         flush     = 1'b0;
         cycle(acc);
         if (acc) idx++;
      end
      chk("stream_count", 32'(emit_count), 32'((c0 + 6) % 16));
      chk("stream_fed", 32'(idx), 32'd6);

      c0 = cnt;
      drv(1, 16'h0001, 16'h0200, 1, 0, 0);
      chk("nop_dropped", 32'(out_valid), 32'd0);
      drv(1, 16'hB405, 16'h0202, 1, 0, 0);
      drv(0, 16'h0, 16'h0, 1, 0, 0);
      chk("nop_count", 32'(emit_count), 32'((c0 + 1) % 16));
      drv(1, 16'hB405, 16'h0204, 1, 0, 1);
      drv(0, 16'h0, 16'h0, 1, 0, 0);
      chk("flush_drop", 32'(out_valid), 32'd0);

      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_insn   = rand_word();
         in_pc     = 16'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         resume    = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         cycle(acc);
      end

      drv(1, 16'h8123, 16'h0300, 0, 0, 0);
      drv(1, 16'h8456, 16'h0302, 0, 0, 0);
      chk("pre_rst_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_count", 32'(emit_count), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd0);
      q.delete();
      st = 0;
      cnt = 0;
      started = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drv(0, 16'h0, 16'h0, 1, 0, 0);
      drv(1, 16'hB405, 16'h0010, 1, 0, 0);
      drv(0, 16'h0, 16'h0, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
